rv32i_mc_sequencer: RTL and testbench

- Multi-cycle control sequencer for the RV32I core: steps each instruction through fetch, decode, execute, memory and writeback.
- Drives instruction and data memory request/ack handshakes and generates the PC, IR and register-file write strobes.
- Runs alongside the combinational control unit, which still supplies the ALU, mux and immediate selects. This block only decides *when* state elements update.
- Watchdog per memory wait; any bus timeout or illegal opcode halts the core until reset.

---
 rtl/rv32i_mc_sequencer_pkg.sv | 36 +++
 rtl/rv32i_mc_sequencer_if.sv | 14 +
 rtl/rv32i_mc_sequencer_watchdog.sv | 37 +++
 rtl/rv32i_mc_sequencer.sv | 121 ++++++++++++
 tb/tb_rv32i_mc_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_mc_sequencer_pkg.sv
// Shared types for the RV32I multi-cycle sequencer: state encodings and the
// base-ISA major opcodes it needs to tell apart.
package rv_seq_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JALR, OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rv32i_mc_sequencer_if.sv
// Instruction and data memory request/ack handshakes between the sequencer
// (master) and the memory side (slave).
interface rv32i_mc_sequencer_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (output imem_req, output dmem_req, output dmem_we,
                    input imem_ack, input dmem_ack);
    modport slave  (input imem_req, input dmem_req, input dmem_we,
                    output imem_ack, output dmem_ack);
endinterface

// File: rtl/rv32i_mc_sequencer_watchdog.sv
// Ack watchdog shared by the fetch and data-memory waits; expired flags the
// last permissible wait cycle passing without an ack.
module rv_ack_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    input  logic ack,
    output logic expired
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run && !ack) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A same-cycle ack always beats expiry.
    assign expired = run && !ack && (count_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/rv32i_mc_sequencer.sv
// Multi-cycle control sequencer: decides when IR, PC and register file update
// and drives the memory handshakes; halts on illegal opcode or bus timeout.
module rv32i_mc_sequencer
    import rv_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [6:0]               opcode,
    rv32i_mc_sequencer_if.master     bus,
    output logic                     ir_we,
    output logic                     pc_we,
    output logic                     rf_we,
    output logic                     retire,
    output logic [2:0]               stage,
    output logic                     halted,
    output logic                     illegal,
    output logic                     bus_err
);
    state_t state_q, state_d;
    logic   illegal_q, bus_err_q;
    logic   set_illegal, set_bus_err;
    logic   wd_run, wd_ack, wd_clear, wd_expired;

    assign wd_run   = (state_q == StFetch) || (state_q == StMem);
    assign wd_ack   = (state_q == StFetch) ? bus.imem_ack : bus.dmem_ack;
    // Every state change restarts the count, so each wait starts from zero.
    assign wd_clear = (state_d != state_q);

    rv_ack_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .run     (wd_run),
        .ack     (wd_ack),
        .expired (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        rf_we        = 1'b0;
        retire       = 1'b0;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        set_illegal  = 1'b0;
        set_bus_err  = 1'b0;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end else if (wd_expired) begin
                    set_bus_err = 1'b1;
                    state_d     = StHalt;
                end
            end
            StDecode: begin
                if (is_legal_op(opcode)) begin
                    state_d = StExec;
                end else begin
                    set_illegal = 1'b1;
                    state_d     = StHalt;
                end
            end
            StExec: begin
                state_d = (opcode == OP_LOAD || opcode == OP_STORE) ? StMem : StWb;
            end
            StMem: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (opcode == OP_STORE);
                if (bus.dmem_ack) begin
                    if (opcode == OP_STORE) begin
                        // Stores retire straight from MEM, nothing to write back.
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (wd_expired) begin
                    set_bus_err = 1'b1;
                    state_d     = StHalt;
                end
            end
            StWb: begin
                pc_we   = 1'b1;
                retire  = 1'b1;
                rf_we   = (opcode != OP_BRANCH);
                state_d = StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_bus_err) bus_err_q <= 1'b1;
        end
    end

    assign stage   = state_q;
    assign halted  = (state_q == StHalt);
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_rv32i_mc_sequencer.sv
// Directed bench for rv32i_mc_sequencer: table of single-instruction runs plus
// hand sequences for illegal opcode, fetch timeout and async reset in MEM.
module tb_rv32i_mc_sequencer;
    import rv_seq_pkg::*;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       ir_we, pc_we, rf_we, retire, halted, illegal, bus_err;
    logic [2:0] stage;

    rv32i_mc_sequencer_if bus ();

    rv32i_mc_sequencer #(
        .TIMEOUT (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .bus     (bus),
        .ir_we   (ir_we),
        .pc_we   (pc_we),
        .rf_we   (rf_we),
        .retire  (retire),
        .stage   (stage),
        .halted  (halted),
        .illegal (illegal),
        .bus_err (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        int         iwait;
        int         dwait;
        int         cycles;
        int         ir_n;
        int         pc_n;
        int         rf_n;
        int         dreq_n;
        int         dwe_n;
    } vec_t;

    vec_t vecs [11];
    int   tests, fails;
    int   n_cyc, n_ir, n_pc, n_rf, n_dreq, n_dwe, n_ret, n_ireq;
    bit   ended_halt, run_done;
    int   trace [32];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Run from a FETCH cycle until retire or HALT, acking each request after
    // the given number of wait cycles.
    task automatic run_instr(input logic [6:0] op, input int iwait, input int dwait);
        int iw, dw;
        iw = 0; dw = 0;
        run_done = 1'b0; ended_halt = 1'b0;
        n_cyc = 0; n_ir = 0; n_pc = 0; n_rf = 0; n_dreq = 0; n_dwe = 0; n_ret = 0; n_ireq = 0;
        opcode = op;
        for (int c = 0; c < 80 && !run_done; c++) begin
            @(negedge clk);
            bus.imem_ack = bus.imem_req && (iw == iwait);
            bus.dmem_ack = bus.dmem_req && (dw == dwait);
            #1;
            if (c < 32) trace[c] = int'(stage);
            if (stage == 3'd7) begin
                ended_halt = 1'b1;
                n_cyc = c;
                run_done = 1'b1;
            end else begin
                n_ir += int'(ir_we);
                n_pc += int'(pc_we);
                n_rf += int'(rf_we);
                if (bus.imem_req) begin n_ireq++; iw++; end
                if (bus.dmem_req) begin
                    n_dreq++;
                    dw++;
                    if (bus.dmem_we) n_dwe++;
                end
                if (retire) begin
                    n_ret++;
                    n_cyc = c + 1;
                    run_done = 1'b1;
                end
            end
        end
        check("run_completes", int'(run_done), 1);
        @(posedge clk);
        #1;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
    endtask

    initial begin
        int bad;
        tests = 0; fails = 0;
        opcode = OP_R;
        vecs[0]  = '{OP_R,      0,  0,  4, 1, 1, 1,  0, 0};
        vecs[1]  = '{OP_LOAD,   0,  3,  8, 1, 1, 1,  4, 0};
        vecs[2]  = '{OP_STORE,  0,  3,  7, 1, 1, 0,  4, 4};
        vecs[3]  = '{OP_BRANCH, 0,  0,  4, 1, 1, 0,  0, 0};
        vecs[4]  = '{OP_I,      2,  0,  6, 1, 1, 1,  0, 0};
        vecs[5]  = '{OP_JAL,    1,  0,  5, 1, 1, 1,  0, 0};
        vecs[6]  = '{OP_LUI,    0,  0,  4, 1, 1, 1,  0, 0};
        vecs[7]  = '{OP_STORE,  1,  0,  5, 1, 1, 0,  1, 1};
        vecs[8]  = '{OP_JALR,   0,  0,  4, 1, 1, 1,  0, 0};
        vecs[9]  = '{OP_AUIPC, 15,  0, 19, 1, 1, 1,  0, 0};
        vecs[10] = '{OP_LOAD,   0, 15, 20, 1, 1, 1, 16, 0};

        // Reset state: every output low while rst is held.
        rst = 1'b1;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        #3;
        check("reset_outputs",
              int'({stage, bus.imem_req, bus.dmem_req, bus.dmem_we, ir_we, pc_we, rf_we,
                    retire, halted, illegal, bus_err}), 0);
        do_reset();
        #1;
        check("idle_after_release", int'(stage), 0);

        for (int i = 0; i < 11; i++) begin
            run_instr(vecs[i].op, vecs[i].iwait, vecs[i].dwait);
            check($sformatf("v%0d_cycles", i), n_cyc, vecs[i].cycles);
            check($sformatf("v%0d_ir_we", i), n_ir, vecs[i].ir_n);
            check($sformatf("v%0d_pc_we", i), n_pc, vecs[i].pc_n);
            check($sformatf("v%0d_rf_we", i), n_rf, vecs[i].rf_n);
            check($sformatf("v%0d_dmem_req", i), n_dreq, vecs[i].dreq_n);
            check($sformatf("v%0d_dmem_we", i), n_dwe, vecs[i].dwe_n);
            check($sformatf("v%0d_retire", i), n_ret, 1);
            check($sformatf("v%0d_next_fetch", i), int'(stage), 1);
            if (i == 0) begin
                check("alu_trace0", trace[0], 1);
                check("alu_trace1", trace[1], 2);
                check("alu_trace2", trace[2], 3);
                check("alu_trace3", trace[3], 5);
            end
        end

        // Illegal opcode: DECODE then HALT with sticky flags.
        run_instr(7'b1111111, 0, 0);
        check("ill_halt_reached", int'(ended_halt), 1);
        check("ill_decode_seen", trace[1], 2);
        check("ill_flags", int'({halted, illegal, bus_err}), 3'b110);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.imem_ack = 1'b1;
            bus.dmem_ack = 1'b1;
            #1;
            if (ir_we || pc_we || rf_we || retire || bus.imem_req || bus.dmem_req ||
                stage != 3'd7) bad++;
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        check("ill_acks_ignored", bad, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ill_rst_clears", int'({stage, halted, illegal, bus_err}), 0);
        do_reset();

        // Fetch timeout: ack withheld, 16 request cycles then HALT.
        run_instr(OP_R, 1000, 0);
        check("to_halt_reached", int'(ended_halt), 1);
        check("to_req_cycles", n_ireq, 16);
        check("to_flags", int'({stage, halted, illegal, bus_err}), 6'b111101);
        check("to_req_dropped", int'(bus.imem_req), 0);
        do_reset();

        // Async reset during a MEM wait.
        opcode = OP_LOAD;
        bad = 1;
        for (int k = 0; k < 20 && bad != 0; k++) begin
            @(negedge clk);
            bus.imem_ack = bus.imem_req;
            #1;
            if (stage == 3'd4) bad = 0;
        end
        bus.imem_ack = 1'b0;
        check("ar_reached_mem", bad, 0);
        @(negedge clk);
        #1;
        check("ar_dmem_req_before", int'(bus.dmem_req), 1);
        rst = 1'b1;
        #1;
        check("ar_dmem_req_async_drop", int'({bus.dmem_req, stage}), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ar_idle", int'({stage, retire}), 0);
        @(negedge clk);
        #1;
        check("ar_fetch", int'({stage, retire}), 4'b0010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
